// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional illegal-op checking is enabled by defining ALU_SHARE_OPCHECK_EN.
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op_select,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             last_id_q, last_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;

    logic idle;
    logic gnt0, gnt1;
    logic acc0, acc1;
    logic op_illegal;

    assign idle = (state_q == IDLE);

    // On contention the requester not served last wins; last_id_q=1 favours req0.
    assign gnt0 = req0_valid && (!req1_valid || last_id_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_id_q);

    assign req0_ready = idle && gnt0;
    assign req1_ready = idle && gnt1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

`ifdef ALU_SHARE_OPCHECK_EN
    assign op_illegal = (op_q == OPW'(1)) || (op_q == OPW'(6)) || (op_q == OPW'(7));
`else
    assign op_illegal = 1'b0;
`endif

    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op_select = (state_q == EXEC && op_illegal) ? '0 : op_q;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = !idle;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_id_d    = last_id_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (acc0) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = req0_op;
                    id_d    = 1'b0;
                    state_d = EXEC;
                end else if (acc1) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = req1_op;
                    id_d    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = op_illegal ? '0 : alu_result;
                rsp_err_d    = op_illegal;
                rsp_id_d     = id_q;
                last_id_d    = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_id_q    <= 1'b1;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_id_q    <= last_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule
